frame_sync_deframer: RTL and testbench

//  Downstream consumer of the serial-in/parallel-out shift register. Watches its

---
 rtl/frame_sync_deframer.sv | 145 ++++++++++++++
 tb/tb_frame_sync_deframer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sync_deframer.sv
// Sync-word hunter and byte deframer fed by a serial-in/parallel-out window; all outputs registered (1 cycle after bit_en).
// No backpressure: advances only on bit_en, idle cycles hold state and drop strobes.
module frame_sync_deframer #(
    parameter int                WIN_W         = 32,
    parameter int                SYNC_W        = 16,
    parameter logic [SYNC_W-1:0] SYNC_WORD     = 16'hA5C3,
    parameter int                PAYLOAD_BYTES = 2,
    parameter int                LOCK_N        = 2,
    parameter int                MISS_N        = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             bit_en,
    input  logic [WIN_W-1:0] win,
    output logic [7:0]       byte_out,
    output logic             byte_valid,
    output logic             frame_start,
    output logic             sync_err,
    output logic             locked,
    output logic [1:0]       state_dbg
);
    localparam int CW = $clog2(WIN_W + 1);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        VERIFY  = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] bit_cnt, bit_cnt_nx, bit_inc;
    logic [7:0]    byte_cnt, byte_cnt_nx, byte_inc;
    logic [3:0]    good_cnt, good_nx, good_inc;
    logic [3:0]    miss_cnt, miss_nx, miss_inc;
    logic [7:0]    byte_nx;
    logic          valid_nx, start_nx, err_nx, locked_nx;
    logic          sync_hit;

    // Upper window bits only matter to wider sync words; fold them so none dangle.
    logic unused_win;
    assign unused_win = ^win;

    assign sync_hit = (win[SYNC_W-1:0] == SYNC_WORD);
    assign bit_inc  = bit_cnt + 1'b1;
    assign byte_inc = byte_cnt + 8'd1;
    assign miss_inc = miss_cnt + 4'd1;
    assign good_inc = (good_cnt >= 4'(LOCK_N)) ? 4'(LOCK_N) : good_cnt + 4'd1;

    always_comb begin
        state_nx    = state;
        bit_cnt_nx  = bit_cnt;
        byte_cnt_nx = byte_cnt;
        good_nx     = good_cnt;
        miss_nx     = miss_cnt;
        byte_nx     = byte_out;
        locked_nx   = locked;
        valid_nx    = 1'b0;
        start_nx    = 1'b0;
        err_nx      = 1'b0;
        if (bit_en) begin
            case (state)
                HUNT: begin
                    if (sync_hit) begin
                        state_nx    = PAYLOAD;
                        start_nx    = 1'b1;
                        good_nx     = 4'd1;
                        miss_nx     = 4'd0;
                        bit_cnt_nx  = '0;
                        byte_cnt_nx = 8'd0;
                        if (LOCK_N == 1)
                            locked_nx = 1'b1;
                    end
                end
                PAYLOAD: begin
                    bit_cnt_nx = bit_inc;
                    if (bit_inc == CW'(8)) begin
                        byte_nx     = win[7:0];
                        valid_nx    = 1'b1;
                        bit_cnt_nx  = '0;
                        byte_cnt_nx = byte_inc;
                        if (byte_inc == 8'(PAYLOAD_BYTES))
                            state_nx = VERIFY;
                    end
                end
                VERIFY: begin
                    bit_cnt_nx = bit_inc;
                    if (bit_inc == CW'(SYNC_W)) begin
                        bit_cnt_nx  = '0;
                        byte_cnt_nx = 8'd0;
                        state_nx    = PAYLOAD;
                        if (sync_hit) begin
                            start_nx = 1'b1;
                            miss_nx  = 4'd0;
                            good_nx  = good_inc;
                            if (good_inc == 4'(LOCK_N))
                                locked_nx = 1'b1;
                        end else begin
                            err_nx = 1'b1;
                            if (miss_inc == 4'(MISS_N)) begin
                                state_nx  = HUNT;
                                locked_nx = 1'b0;
                                good_nx   = 4'd0;
                                miss_nx   = 4'd0;
                            end else begin
                                // Flywheel: keep framing on the old alignment.
                                miss_nx = miss_inc;
                                good_nx = 4'd0;
                            end
                        end
                    end
                end
                default: state_nx = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= HUNT;
            bit_cnt     <= '0;
            byte_cnt    <= 8'd0;
            good_cnt    <= 4'd0;
            miss_cnt    <= 4'd0;
            byte_out    <= 8'd0;
            byte_valid  <= 1'b0;
            frame_start <= 1'b0;
            sync_err    <= 1'b0;
            locked      <= 1'b0;
        end else begin
            state       <= state_nx;
            bit_cnt     <= bit_cnt_nx;
            byte_cnt    <= byte_cnt_nx;
            good_cnt    <= good_nx;
            miss_cnt    <= miss_nx;
            byte_out    <= byte_nx;
            byte_valid  <= valid_nx;
            frame_start <= start_nx;
            sync_err    <= err_nx;
            locked      <= locked_nx;
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_frame_sync_deframer.sv
// Bench for frame_sync_deframer: bit streams framed by a position-based reference model, checked every cycle.
module tb_frame_sync_deframer;
    localparam int          WIN_W  = 32;
    localparam int          SW     = 16;
    localparam logic [15:0] SYNC   = 16'hA5C3;
    localparam int          PB     = 2;
    localparam int          LOCK_N = 2;
    localparam int          MISS_N = 2;
    localparam int          MAXB   = 2048;
    localparam logic [1:0]  HUNT_S = 2'd0, PAY_S = 2'd1, VER_S = 2'd2;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             bit_en = 1'b0;
    logic [WIN_W-1:0] win = '0;
    logic [7:0]       byte_out;
    logic             byte_valid, frame_start, sync_err, locked;
    logic [1:0]       state_dbg;

    int total = 0;
    int bad   = 0;

    bit          bits[$];
    logic [15:0] wh     [MAXB];
    bit          e_bv   [MAXB];
    bit          e_fs   [MAXB];
    bit          e_err  [MAXB];
    bit          e_lk   [MAXB];
    logic [7:0]  e_byte [MAXB];
    logic [1:0]  e_st   [MAXB];
    logic [7:0]  last_byte;

    frame_sync_deframer #(
        .WIN_W(WIN_W), .SYNC_W(SW), .SYNC_WORD(SYNC),
        .PAYLOAD_BYTES(PB), .LOCK_N(LOCK_N), .MISS_N(MISS_N)
    ) dut (
        .clk(clk), .rstn(rstn), .bit_en(bit_en), .win(win),
        .byte_out(byte_out), .byte_valid(byte_valid), .frame_start(frame_start),
        .sync_err(sync_err), .locked(locked), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input bit bv, input bit fs, input bit er,
                              input logic [7:0] by, input logic [1:0] st, input bit lk);
        chk({tag, ".byte_valid"},  byte_valid,  bv);
        chk({tag, ".frame_start"}, frame_start, fs);
        chk({tag, ".sync_err"},    sync_err,    er);
        chk({tag, ".byte_out"},    byte_out,    by);
        chk({tag, ".state"},       state_dbg,   st);
        chk({tag, ".locked"},      locked,      lk);
    endtask

    task automatic push(input logic [15:0] v, input int nb);
        for (int j = nb - 1; j >= 0; j--) bits.push_back(v[j]);
    endtask

    task automatic mark(input int a, input int b, input logic [1:0] s, input bit l, input int n);
        for (int x = a; x <= b && x < n; x++) begin
            e_st[x] = s;
            e_lk[x] = l;
        end
    endtask

    // Framing by absolute bit position: a frame is sync-end, PB bytes, then the next sync-end.
    task automatic build_model(input int n);
        int i, k, p, pend, e, good, miss;
        bit lk, hunting;
        logic [15:0] w;
        w = '0;
        for (int x = 0; x < n; x++) begin
            w = {w[14:0], bits[x]};
            wh[x] = w;
            e_bv[x] = 0; e_fs[x] = 0; e_err[x] = 0; e_byte[x] = '0;
            e_st[x] = HUNT_S; e_lk[x] = 0;
        end
        i = 0; lk = 0; good = 0; miss = 0;
        while (i < n) begin
            k = i;
            while (k < n && wh[k] != SYNC) k++;
            mark(i, k - 1, HUNT_S, 0, n);
            if (k >= n) break;
            e_fs[k] = 1; good = 1; miss = 0; lk = (LOCK_N == 1);
            p = k; hunting = 0;
            while (!hunting && p < n) begin
                mark(p, p, PAY_S, lk, n);
                pend = p + 8 * PB;
                for (int b = 1; b <= PB; b++)
                    if (p + 8 * b < n) begin
                        e_bv[p + 8 * b]   = 1;
                        e_byte[p + 8 * b] = wh[p + 8 * b][7:0];
                    end
                mark(p + 1, pend - 1, PAY_S, lk, n);
                mark(pend, pend + SW - 1, VER_S, lk, n);
                e = pend + SW;
                if (e >= n) begin
                    p = n;
                end else if (wh[e] == SYNC) begin
                    e_fs[e] = 1; miss = 0;
                    good = (good + 1 > LOCK_N) ? LOCK_N : good + 1;
                    if (good == LOCK_N) lk = 1;
                    p = e;
                end else begin
                    e_err[e] = 1; miss++;
                    if (miss == MISS_N) begin
                        lk = 0; good = 0; miss = 0;
                        mark(e, e, HUNT_S, 0, n);
                        i = e + 1; hunting = 1;
                    end else begin
                        good = 0; p = e;
                    end
                end
            end
            if (!hunting) i = n;
        end
    endtask

    task automatic do_reset();
        bit_en = 0; win = '0; rstn = 0;
        repeat (2) @(posedge clk);
        #1 check_outs("reset", 0, 0, 0, 8'h00, HUNT_S, 0);
        @(negedge clk) rstn = 1;
    endtask

    task automatic run_stream(input string tag, input int gap_pct);
        int n;
        logic [WIN_W-1:0] sh;
        logic [1:0] pst;
        bit plk;
        n = bits.size();
        build_model(n);
        do_reset();
        sh = '0; last_byte = 8'h00; pst = HUNT_S; plk = 0;
        for (int idx = 0; idx < n; idx++) begin
            for (int g = 0; g < 4 && $urandom_range(99) < gap_pct; g++) begin
                @(negedge clk) bit_en = 0;
                @(posedge clk);
                #1 check_outs({tag, ".gap"}, 0, 0, 0, last_byte, pst, plk);
            end
            @(negedge clk);
            sh = {sh[WIN_W-2:0], bits[idx]};
            win = sh; bit_en = 1;
            @(posedge clk);
            if (e_bv[idx]) last_byte = e_byte[idx];
            #1 check_outs(tag, e_bv[idx], e_fs[idx], e_err[idx], last_byte, e_st[idx], e_lk[idx]);
            pst = e_st[idx]; plk = e_lk[idx];
        end
        @(negedge clk) bit_en = 0;
        @(posedge clk);
        #1 check_outs({tag, ".idle"}, 0, 0, 0, last_byte, pst, plk);
    endtask

    initial begin
        logic [15:0] g;
        bit b;

        // Single frame: sync then two bytes, ends in VERIFY.
        bits.delete();
        push(SYNC, 16); push(16'h12, 8); push(16'h34, 8);
        run_stream("hunt_bytes", 0);

        // Two good frames reach lock.
        bits.delete();
        push(SYNC, 16); push(16'h12, 8); push(16'h34, 8);
        push(SYNC, 16); push(16'h56, 8); push(16'h78, 8);
        run_stream("lock", 0);

        // Lock, one flywheel miss, then loss back to HUNT.
        bits.delete();
        push(SYNC, 16); push(16'h12, 8); push(16'h34, 8);
        push(SYNC, 16); push(16'h56, 8); push(16'h78, 8);
        push(16'h0000, 16); push(16'h9A, 8); push(16'hBC, 8);
        push(16'h0000, 16); push(16'hDE, 5);
        run_stream("flywheel", 0);

        // Lock scenario with stalls, sync pattern embedded in payload.
        bits.delete();
        push(SYNC, 16); push(16'h12, 8); push(16'h34, 8);
        push(SYNC, 16); push(16'h56, 8); push(16'h78, 8);
        push(SYNC, 16); push(16'hA5, 8); push(16'hC3, 8);
        push(SYNC, 16); push(16'h9A, 8); push(16'hBC, 8);
        run_stream("stall", 35);

        // Random framed streams: random prefix, payloads, occasional bad syncs, gaps.
        for (int r = 0; r < 4; r++) begin
            bits.delete();
            repeat ($urandom_range(20)) push(16'($urandom_range(1)), 1);
            for (int f = 0; f < 7; f++) begin
                if (f > 0 && $urandom_range(4) == 0) push(16'($urandom), 16);
                else push(SYNC, 16);
                for (int k = 0; k < PB; k++) push(16'($urandom_range(255)), 8);
            end
            run_stream("random", 25);
        end

        // Asynchronous reset in the middle of a payload byte.
        bits.delete();
        push(SYNC, 16); push(16'h12, 8); push(16'h5, 3);
        run_stream("pre_reset", 0);
        #2 rstn = 0;
        #1 check_outs("async_reset", 0, 0, 0, 8'h00, HUNT_S, 0);
        @(negedge clk) rstn = 1;

        // Garbage with the sync word suppressed.
        bits.delete();
        g = '0;
        for (int x = 0; x < 1000; x++) begin
            b = 1'($urandom_range(1));
            if ({g[14:0], b} == SYNC) b = ~b;
            g = {g[14:0], b};
            bits.push_back(b);
        end
        run_stream("garbage", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
